// File: rtl/dll_enc_arbiter.sv
// rtl/dll_enc_arbiter.sv - round-robin sharing of one two-stage DLL priority encoder
// Optional issue counter port enabled by DLL_ENC_ARB_STATS_EN.
module dll_enc_arbiter #(
    parameter int NUM_CHAN  = 4,
    parameter int CHAN_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NUM_CHAN-1:0]    req,
    input  logic [19*NUM_CHAN-1:0] req_value,
    output logic [NUM_CHAN-1:0]    grant,
    output logic [18:0]            enc_in,
    input  logic [4:0]             enc_out,
    output logic                   result_valid,
    output logic [CHAN_BITS-1:0]   result_chan,
    output logic [4:0]             result_pos,
    output logic                   idle
`ifdef DLL_ENC_ARB_STATS_EN
    ,
    output logic [15:0]            issue_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [CHAN_BITS-1:0] ptr;
    logic [NUM_CHAN-1:0]  eligible;
    logic                 sel_found;
    logic [CHAN_BITS-1:0] sel_idx;
    int                   cand;
    logic                 issue;

    logic                 tag0_v, tag1_v, tag2_v;
    logic [CHAN_BITS-1:0] tag0_c, tag1_c, tag2_c;

    // The channel granted last edge still shows req high this cycle.
    assign eligible = req & ~grant;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_CHAN)
                cand = cand - NUM_CHAN;
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = CHAN_BITS'(cand);
            end
        end
    end

    assign issue = (state == S_RUN) && en && sel_found;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (en) state_next = S_RUN;
            S_RUN:   if (!en) state_next = S_DRAIN;
            S_DRAIN: begin
                // Look at next-cycle tags so idle rises on the edge retiring the last issue.
                if (en)
                    state_next = S_RUN;
                else if (!tag0_v && !tag1_v)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            grant  <= '0;
            enc_in <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                grant  <= NUM_CHAN'(1) << sel_idx;
                enc_in <= req_value[19*int'(sel_idx) +: 19];
                ptr    <= (sel_idx == CHAN_BITS'(NUM_CHAN - 1)) ? '0 : sel_idx + 1'b1;
            end else begin
                grant <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag0_v       <= 1'b0;
            tag1_v       <= 1'b0;
            tag2_v       <= 1'b0;
            tag0_c       <= '0;
            tag1_c       <= '0;
            tag2_c       <= '0;
            result_valid <= 1'b0;
            result_chan  <= '0;
            result_pos   <= '0;
        end else begin
            tag0_v <= issue;
            tag0_c <= sel_idx;
            tag1_v <= tag0_v;
            tag1_c <= tag0_c;
            tag2_v <= tag1_v;
            tag2_c <= tag1_c;
            result_valid <= tag2_v;
            if (tag2_v) begin
                result_chan <= tag2_c;
                result_pos  <= enc_out;
            end
        end
    end

    assign idle = (state == S_IDLE) && !tag0_v && !tag1_v && !tag2_v;

`ifdef DLL_ENC_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            issue_count <= '0;
        else if (!en && idle)
            issue_count <= '0;
        else if (issue && issue_count != 16'hFFFF)
            issue_count <= issue_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dll_enc_arbiter.sv
// tb/tb_dll_enc_arbiter.sv - directed bench for dll_enc_arbiter with a two-stage encoder model
module tb_dll_enc_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [75:0] req_value;
    logic [3:0]  grant;
    logic [18:0] enc_in;
    logic [4:0]  enc_out;
    logic        result_valid;
    logic [1:0]  result_chan;
    logic [4:0]  result_pos;
    logic        idle;
`ifdef DLL_ENC_ARB_STATS_EN
    logic [15:0] issue_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dll_enc_arbiter #(.NUM_CHAN(4), .CHAN_BITS(2)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .req(req),
        .req_value(req_value),
        .grant(grant),
        .enc_in(enc_in),
        .enc_out(enc_out),
        .result_valid(result_valid),
        .result_chan(result_chan),
        .result_pos(result_pos),
        .idle(idle)
`ifdef DLL_ENC_ARB_STATS_EN
        ,
        .issue_count(issue_count)
`endif
    );

    // Shared encoder: MSB position 18..8, else 7; two register stages.
    logic [18:0] enc_s1 = '0;
    logic [4:0]  enc_s2 = '0;

    function automatic logic [4:0] msb_pos(input logic [18:0] v);
        logic [4:0] p;
        p = 5'd7;
        for (int b = 8; b <= 18; b++)
            if (v[b]) p = 5'(b);
        return p;
    endfunction

    always @(posedge clk) begin
        enc_s1 <= enc_in;
        enc_s2 <= msb_pos(enc_s1);
    end
    assign enc_out = enc_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int ch, input logic [18:0] v);
        req_value[19*ch +: 19] = v;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant == 4'b0 && n < 20) begin
            step(1);
            n++;
        end
        chk("grant_seen", 32'(grant != 4'b0), 32'd1);
    endtask

    logic [18:0] bval [5];
    logic [4:0]  bpos [5];
    logic [18:0] cval [4];
    logic [4:0]  cpos [4];
    int          rv_count;

    initial begin
        bval = '{19'h00100, 19'h01000, 19'h02000, 19'h000FF, 19'h00000};
        bpos = '{5'd8, 5'd12, 5'd13, 5'd7, 5'd7};
        cval = '{19'h00100, 19'h00800, 19'h08000, 19'h20000};
        cpos = '{5'd8, 5'd11, 5'd15, 5'd17};

        reset     = 1'b1;
        en        = 1'b0;
        req       = 4'b0;
        req_value = '0;
        step(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_chan", 32'(result_chan), 32'd0);
        chk("rst_pos", 32'(result_pos), 32'd0);
        chk("rst_enc_in", 32'(enc_in), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        reset = 1'b0;
        step(1);

        // Single request on ch2
        en  = 1'b1;
        req = 4'b0100;
        set_val(2, 19'h40000);
        step(1);
        chk("single_pre_grant", 32'(grant), 32'd0);
        step(1);
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_enc_in", 32'(enc_in), 32'h40000);
        req = 4'b0;
        step(1);
        chk("single_grant_drop", 32'(grant), 32'd0);
        step(1);
        chk("single_no_early", 32'(result_valid), 32'd0);
        step(1);
        chk("single_valid", 32'(result_valid), 32'd1);
        chk("single_chan", 32'(result_chan), 32'd2);
        chk("single_pos", 32'(result_pos), 32'd18);
        step(1);
        chk("single_pulse", 32'(result_valid), 32'd0);

        // Encoder boundary values on ch0
        for (int i = 0; i < 5; i++) begin
            set_val(0, bval[i]);
            req = 4'b0001;
            wait_grant();
            chk("bnd_grant", 32'(grant), 32'b0001);
            req = 4'b0;
            step(3);
            chk("bnd_valid", 32'(result_valid), 32'd1);
            chk("bnd_chan", 32'(result_chan), 32'd0);
            chk("bnd_pos", 32'(result_pos), 32'(bpos[i]));
        end

        // Continuous requests from all channels, starting from ptr=0
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) set_val(c, cval[c]);
        en  = 1'b1;
        req = 4'b1111;
        step(1);
        chk("cont_first_idle_edge", 32'(grant), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("cont_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            chk("cont_enc_in", 32'(enc_in), 32'(cval[k % 4]));
            if (k >= 3) begin
                chk("cont_valid", 32'(result_valid), 32'd1);
                chk("cont_chan", 32'((k - 3) % 4), 32'(result_chan));
                chk("cont_pos", 32'(result_pos), 32'(cpos[(k - 3) % 4]));
            end
        end

        // Drain: en drops with work in flight
        en = 1'b0;
        step(1);
        chk("drain_no_grant", 32'(grant), 32'd0);
        chk("drain_r1_valid", 32'(result_valid), 32'd1);
        chk("drain_r1_chan", 32'(result_chan), 32'd1);
        chk("drain_r1_pos", 32'(result_pos), 32'd11);
        step(1);
        chk("drain_no_grant2", 32'(grant), 32'd0);
        chk("drain_r2_chan", 32'(result_chan), 32'd2);
        chk("drain_r2_pos", 32'(result_pos), 32'd15);
        chk("drain_busy", 32'(idle), 32'd0);
        step(1);
        chk("drain_r3_valid", 32'(result_valid), 32'd1);
        chk("drain_r3_chan", 32'(result_chan), 32'd3);
        chk("drain_r3_pos", 32'(result_pos), 32'd17);
        chk("drain_idle", 32'(idle), 32'd1);
        step(1);
        chk("drain_done_valid", 32'(result_valid), 32'd0);
        chk("drain_idle_hold", 32'(idle), 32'd1);
        req = 4'b0;

        // Asynchronous reset one cycle after a grant
        set_val(0, 19'h40000);
        set_val(1, 19'h01000);
        req = 4'b0011;
        en  = 1'b1;
        wait_grant();
        chk("arst_pre_grant", 32'(grant), 32'b0001);
        req = 4'b0;
        step(1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_enc_in", 32'(enc_in), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_pos", 32'(result_pos), 32'd0);
        step(2);
        #3;
        reset = 1'b0;
        rv_count = 0;
        repeat (6) begin
            step(1);
            if (result_valid) rv_count++;
        end
        chk("arst_lost_issue", 32'(rv_count), 32'd0);
        req = 4'b0011;
        wait_grant();
        chk("arst_tie_ch0", 32'(grant), 32'b0001);
        req = 4'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
